// File: rtl/stream_demux_1ton_pkg.sv
// Shared types for the registered 1-to-N packet demux (stream_demux_1ton).
// Optional drop-counter support is compiled in with DEMUX_DROP_EN.
package stream_demux_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ROUTE = 1'b1
   } demux_state_t;

   localparam int DROP_CNT_W = 16;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/stream_demux_1ton_if.sv
// Handshake bundle for stream_demux_1ton: one input stream, N valid/ready output channels
// sharing a single data/last bus.
interface stream_demux_1ton_if #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 8,
   parameter int SEL_W  = 3
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic [SEL_W-1:0]  in_sel;
   logic [N_OUT-1:0]  out_valid;
   logic [N_OUT-1:0]  out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output in_valid, in_data, in_last, in_sel, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, in_sel, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/stream_demux_1ton_out_reg.sv
// One-entry {data, last, ch} output holding register for stream_demux_1ton.
// Accepts a new beat whenever it is empty or its current beat drains this cycle.
module demux_out_reg
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 8,
   parameter int SEL_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   input  logic [SEL_W-1:0]  i_ch,
   input  logic [N_OUT-1:0]  i_out_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic [SEL_W-1:0]  o_ch,
   output logic              o_in_ready
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic [SEL_W-1:0]  r_ch;
   logic              w_drain;

   assign w_drain    = r_valid && i_out_ready[r_ch];
   assign o_in_ready = !r_valid || i_out_ready[r_ch];

   // A write in the same cycle as a drain simply overwrites, keeping valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_ch    <= '0;
      end else if (i_wr) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
         r_ch    <= i_ch;
      end else if (w_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_ch    = r_ch;

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N packet demux; channel is locked from first beat until the last beat.
// Define DEMUX_DROP_EN to discard and count packets whose in_sel >= N_OUT.
module stream_demux_1ton
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 8,
   parameter int SEL_W  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   stream_demux_1ton_if.slave    bus,
   output logic                  busy,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam logic [SEL_W:0]   LP_N_OUT   = (SEL_W+1)'(N_OUT);
   localparam logic [SEL_W-1:0] LP_LAST_CH = SEL_W'(N_OUT - 1);

   demux_state_t     r_state;
   logic [SEL_W-1:0] r_ch;
   logic             w_oob;
   logic             w_drop;
   logic             w_accept;
   logic             w_wr;
   logic             w_buf_ready;
   logic             w_buf_valid;
   logic [SEL_W-1:0] w_sel_map;
   logic [SEL_W-1:0] w_ch;
   logic [SEL_W-1:0] w_buf_ch;

   assign w_oob     = {1'b0, bus.in_sel} >= LP_N_OUT;
   assign w_sel_map = w_oob ? LP_LAST_CH : bus.in_sel;
   assign w_ch      = (r_state == IDLE) ? w_sel_map : r_ch;

`ifdef DEMUX_DROP_EN
   logic                  r_drop;
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   assign w_drop = (r_state == IDLE) ? w_oob : r_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop     <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_accept) begin
         if (r_state == IDLE) begin
            r_drop <= w_oob;
         end
         if (w_drop && bus.in_last) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
         end
      end
   end

   assign drop_cnt = r_drop_cnt;
`else
   assign w_drop   = 1'b0;
   assign drop_cnt = '0;
`endif

   // Dropped beats bypass the buffer, so they are always accepted.
   assign bus.in_ready = !rst && (w_drop || w_buf_ready);
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_wr         = w_accept && !w_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ch    <= '0;
      end else if (w_accept) begin
         if (r_state == IDLE) begin
            r_ch <= w_sel_map;
         end
         r_state <= bus.in_last ? IDLE : ROUTE;
      end
   end

   assign busy = (r_state == ROUTE);

   demux_out_reg #(
      .DATA_W (DATA_W),
      .N_OUT  (N_OUT),
      .SEL_W  (SEL_W)
   ) u_out_reg (
      .clk         (clk),
      .rst         (rst),
      .i_wr        (w_wr),
      .i_data      (bus.in_data),
      .i_last      (bus.in_last),
      .i_ch        (w_ch),
      .i_out_ready (bus.out_ready),
      .o_valid     (w_buf_valid),
      .o_data      (bus.out_data),
      .o_last      (bus.out_last),
      .o_ch        (w_buf_ch),
      .o_in_ready  (w_buf_ready)
   );

   always_comb begin
      bus.out_valid = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         bus.out_valid[k] = w_buf_valid && (w_buf_ch == SEL_W'(k));
      end
   end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Self-checking bench for stream_demux_1ton: an N_OUT=8 instance with a beat scoreboard and
// per-cycle vector table, plus an N_OUT=6 instance for the out-of-range select behaviour.
module tb_stream_demux_1ton;
   import stream_demux_pkg::*;

   localparam int DW = 8;
   localparam int NA = 8;
   localparam int NB = 6;
   localparam int SW = 3;
`ifdef DEMUX_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        busy_a, busy_b;
   logic [15:0] drop_a, drop_b;

   always #5 clk = ~clk;

   stream_demux_1ton_if #(.DATA_W(DW), .N_OUT(NA), .SEL_W(SW)) bus_a ();
   stream_demux_1ton_if #(.DATA_W(DW), .N_OUT(NB), .SEL_W(SW)) bus_b ();

   stream_demux_1ton #(.DATA_W(DW), .N_OUT(NA), .SEL_W(SW)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a), .drop_cnt(drop_a));
   stream_demux_1ton #(.DATA_W(DW), .N_OUT(NB), .SEL_W(SW)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b), .drop_cnt(drop_b));

   int total = 0;
   int bad   = 0;
   int n_pop = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard on instance A: beats pushed on input accept, popped on output handshake.
   typedef struct packed {
      logic [SW-1:0] ch;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   beat_t         sbq[$];
   beat_t         sb_e;
   logic          m_open = 1'b0;
   logic [SW-1:0] m_ch   = '0;
   logic [SW-1:0] m_sel;

   always @(negedge clk) begin
      chk("a_onehot", ($countones(bus_a.out_valid) <= 1), 1'b1);
      for (int k = 0; k < NA; k++) begin
         if (bus_a.out_valid[k] && bus_a.out_ready[k]) begin
            n_pop++;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: got beat ch=%0d data=%0h, expected none", k, bus_a.out_data);
            end else begin
               sb_e = sbq.pop_front();
               chk("sb_beat", {SW'(k), bus_a.out_last, bus_a.out_data}, sb_e);
            end
         end
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
         m_sel = m_open ? m_ch : bus_a.in_sel;
         sbq.push_back('{ch: m_sel, last: bus_a.in_last, data: bus_a.in_data});
         m_ch   = m_sel;
         m_open = !bus_a.in_last;
      end
      if (rst) begin
         sbq.delete();
         m_open = 1'b0;
      end
   end

   task automatic step_a(input logic v, input logic [7:0] d, input logic l,
                         input logic [2:0] s, input logic [7:0] rdy);
      @(posedge clk);
      #1;
      bus_a.in_valid  = v;
      bus_a.in_data   = d;
      bus_a.in_last   = l;
      bus_a.in_sel    = s;
      bus_a.out_ready = rdy;
      @(negedge clk);
   endtask

   task automatic step_b(input logic v, input logic [7:0] d, input logic l,
                         input logic [2:0] s, input logic [5:0] rdy);
      @(posedge clk);
      #1;
      bus_b.in_valid  = v;
      bus_b.in_data   = d;
      bus_b.in_last   = l;
      bus_b.in_sel    = s;
      bus_b.out_ready = rdy;
      @(negedge clk);
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       l;
      logic [2:0] s;
      logic       ir;
      logic [7:0] ov;
      logic [7:0] od;
      logic       ol;
      logic       bz;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic [2:0] s,
                               input logic ir, input logic [7:0] ov, input logic [7:0] od,
                               input logic ol, input logic bz);
      vec_t r;
      r.v = v; r.d = d; r.l = l; r.s = s; r.ir = ir; r.ov = ov; r.od = od; r.ol = ol; r.bz = bz;
      return r;
   endfunction

   vec_t tbl[15];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1);
   end

   initial begin
      // 3-beat packet to ch5, then single-beat packets 0/1/7, then packets to ch3 and ch4 back to back
      tbl[0]  = mk(1, 8'd11,  0, 3'd5, 1, 8'h00, 8'd0,   0, 0);
      tbl[1]  = mk(1, 8'd22,  0, 3'd5, 1, 8'h20, 8'd11,  0, 1);
      tbl[2]  = mk(1, 8'd33,  1, 3'd5, 1, 8'h20, 8'd22,  0, 1);
      tbl[3]  = mk(0, 8'd0,   0, 3'd0, 1, 8'h20, 8'd33,  1, 0);
      tbl[4]  = mk(0, 8'd0,   0, 3'd0, 1, 8'h00, 8'd0,   0, 0);
      tbl[5]  = mk(1, 8'hA0,  1, 3'd0, 1, 8'h00, 8'd0,   0, 0);
      tbl[6]  = mk(1, 8'hA1,  1, 3'd1, 1, 8'h01, 8'hA0,  1, 0);
      tbl[7]  = mk(1, 8'hA7,  1, 3'd7, 1, 8'h02, 8'hA1,  1, 0);
      tbl[8]  = mk(0, 8'd0,   0, 3'd0, 1, 8'h80, 8'hA7,  1, 0);
      tbl[9]  = mk(0, 8'd0,   0, 3'd0, 1, 8'h00, 8'd0,   0, 0);
      tbl[10] = mk(1, 8'hB0,  0, 3'd3, 1, 8'h00, 8'd0,   0, 0);
      tbl[11] = mk(1, 8'hB1,  1, 3'd4, 1, 8'h08, 8'hB0,  0, 1);
      tbl[12] = mk(1, 8'hC0,  1, 3'd4, 1, 8'h08, 8'hB1,  1, 0);
      tbl[13] = mk(0, 8'd0,   0, 3'd0, 1, 8'h10, 8'hC0,  1, 0);
      tbl[14] = mk(0, 8'd0,   0, 3'd0, 1, 8'h00, 8'd0,   0, 0);

      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0; bus_a.in_sel = '0;
      bus_a.out_ready = '1;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0; bus_b.in_sel = '0;
      bus_b.out_ready = '1;
      rst = 1'b1;

      @(negedge clk);
      chk("rst_in_ready", bus_a.in_ready, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", bus_a.in_ready, 1'b1);
      chk("post_rst_out_valid", bus_a.out_valid, 8'h00);
      chk("post_rst_out_data", bus_a.out_data, 8'h00);
      chk("post_rst_out_last", bus_a.out_last, 1'b0);
      chk("post_rst_busy", busy_a, 1'b0);
      chk("post_rst_drop_a", drop_a, 16'h0);
      chk("post_rst_drop_b", drop_b, 16'h0);

      for (int i = 0; i < 15; i++) begin
         step_a(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s, 8'hFF);
         chk($sformatf("vec%0d_in_ready", i), bus_a.in_ready, tbl[i].ir);
         chk($sformatf("vec%0d_out_valid", i), bus_a.out_valid, tbl[i].ov);
         chk($sformatf("vec%0d_busy", i), busy_a, tbl[i].bz);
         if (tbl[i].ov != 8'h00) begin
            chk($sformatf("vec%0d_out_data", i), bus_a.out_data, tbl[i].od);
            chk($sformatf("vec%0d_out_last", i), bus_a.out_last, tbl[i].ol);
         end
      end

      // Channel locked to 2 although in_sel moves to 6 after the first beat
      step_a(1, 8'h21, 0, 3'd2, 8'hFF);
      chk("lock_busy0", busy_a, 1'b0);
      step_a(1, 8'h22, 0, 3'd6, 8'hFF);
      chk("lock_busy1", busy_a, 1'b1);
      chk("lock_ov1", bus_a.out_valid, 8'h04);
      chk("lock_d1", bus_a.out_data, 8'h21);
      step_a(1, 8'h23, 0, 3'd6, 8'hFF);
      chk("lock_busy2", busy_a, 1'b1);
      chk("lock_ov2", bus_a.out_valid, 8'h04);
      step_a(1, 8'h24, 1, 3'd6, 8'hFF);
      chk("lock_busy3", busy_a, 1'b1);
      chk("lock_ov3", bus_a.out_valid, 8'h04);
      chk("lock_d3", bus_a.out_data, 8'h23);
      step_a(0, 8'h00, 0, 3'd0, 8'hFF);
      chk("lock_busy4", busy_a, 1'b0);
      chk("lock_ov4", bus_a.out_valid, 8'h04);
      chk("lock_last4", bus_a.out_last, 1'b1);
      step_a(0, 8'h00, 0, 3'd0, 8'hFF);
      chk("lock_ov5", bus_a.out_valid, 8'h00);

      // Stall ch2 for 5 cycles mid-packet; other channels' ready must not matter
      step_a(1, 8'h41, 0, 3'd2, 8'hFF);
      step_a(1, 8'h42, 0, 3'd2, 8'hFF);
      chk("stall_pre_d", bus_a.out_data, 8'h41);
      for (int c = 0; c < 5; c++) begin
         step_a(1, 8'h43, 0, 3'd2, 8'hFB);
         chk($sformatf("stall%0d_in_ready", c), bus_a.in_ready, 1'b0);
         chk($sformatf("stall%0d_ov", c), bus_a.out_valid, 8'h04);
         chk($sformatf("stall%0d_d", c), bus_a.out_data, 8'h42);
         chk($sformatf("stall%0d_busy", c), busy_a, 1'b1);
      end
      step_a(1, 8'h43, 0, 3'd2, 8'hFF);
      chk("release_in_ready", bus_a.in_ready, 1'b1);
      chk("release_d", bus_a.out_data, 8'h42);
      step_a(1, 8'h44, 1, 3'd2, 8'hFF);
      chk("release_d2", bus_a.out_data, 8'h43);
      step_a(0, 8'h00, 0, 3'd0, 8'hFF);
      chk("release_d3", bus_a.out_data, 8'h44);
      chk("release_last3", bus_a.out_last, 1'b1);
      step_a(0, 8'h00, 0, 3'd0, 8'hFF);
      chk("release_ov4", bus_a.out_valid, 8'h00);

      // Reset during beat 2 of a 4-beat packet to ch3
      step_a(1, 8'h51, 0, 3'd3, 8'hFF);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus_a.in_data = 8'h52;
      @(negedge clk);
      chk("mid_rst_in_ready", bus_a.in_ready, 1'b0);
      chk("mid_rst_ov", bus_a.out_valid, 8'h08);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_a.in_data = 8'h53;
      bus_a.in_sel  = 3'd6;
      @(negedge clk);
      chk("after_rst_ov", bus_a.out_valid, 8'h00);
      chk("after_rst_busy", busy_a, 1'b0);
      chk("after_rst_in_ready", bus_a.in_ready, 1'b1);
      step_a(1, 8'h54, 1, 3'd1, 8'hFF);
      chk("after_rst_ov2", bus_a.out_valid, 8'h40);
      chk("after_rst_d2", bus_a.out_data, 8'h53);
      chk("after_rst_busy2", busy_a, 1'b1);
      step_a(0, 8'h00, 0, 3'd0, 8'hFF);
      chk("after_rst_ov3", bus_a.out_valid, 8'h40);
      chk("after_rst_d3", bus_a.out_data, 8'h54);
      chk("after_rst_busy3", busy_a, 1'b0);
      step_a(0, 8'h00, 0, 3'd0, 8'hFF);

      // N_OUT=6 instance: sel=7 is out of range
      step_b(1, 8'h61, 0, 3'd7, 6'h3F);
      chk("oob_in_ready1", bus_b.in_ready, 1'b1);
      chk("oob_busy1", busy_b, 1'b0);
      step_b(1, 8'h62, 1, 3'd0, 6'h3F);
      chk("oob_in_ready2", bus_b.in_ready, 1'b1);
      chk("oob_busy2", busy_b, 1'b1);
      chk("oob_ov2", bus_b.out_valid, DROP ? 6'h00 : 6'h20);
      chk("oob_drop2", drop_b, 16'd0);
      step_b(0, 8'h00, 0, 3'd0, 6'h3F);
      chk("oob_busy3", busy_b, 1'b0);
      chk("oob_ov3", bus_b.out_valid, DROP ? 6'h00 : 6'h20);
      chk("oob_drop3", drop_b, DROP ? 16'd1 : 16'd0);
      step_b(1, 8'h63, 1, 3'd4, 6'h3F);
      step_b(0, 8'h00, 0, 3'd0, 6'h3F);
      chk("b_normal_ov", bus_b.out_valid, 6'h10);
      chk("b_normal_d", bus_b.out_data, 8'h63);
      // Out-of-range beat offered while the buffer is stalled
      step_b(1, 8'h65, 1, 3'd4, 6'h00);
      step_b(1, 8'h66, 1, 3'd7, 6'h00);
      chk("oob_stall_in_ready", bus_b.in_ready, DROP);
      chk("oob_stall_d", bus_b.out_data, 8'h65);
      step_b(0, 8'h00, 0, 3'd0, 6'h00);
      chk("oob_stall_drop", drop_b, DROP ? 16'd2 : 16'd0);
      chk("oob_stall_ov", bus_b.out_valid, 6'h10);
      chk("oob_stall_d2", bus_b.out_data, 8'h65);
      step_b(0, 8'h00, 0, 3'd0, 6'h3F);
      step_b(0, 8'h00, 0, 3'd0, 6'h3F);
      chk("b_final_ov", bus_b.out_valid, 6'h00);

      chk("sb_drained", sbq.size(), 0);
      chk("beat_count", n_pop, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
